// File: rtl/sr_latch_sequencer_if.sv
// ============================================================================
//  Module      : sr_latch_sequencer_if
//  Description : Request/grant and latch-drive signal bundle for the shared
//                NAND set/reset latch sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sr_latch_sequencer_if #(
  parameter int N = 2
);
  logic [N-1:0] req;
  logic [N-1:0] req_set;
  logic [N-1:0] grant;
  logic         busy;
  logic         done;
  logic         err;
  logic         preset_n;
  logic         clear_n;
  logic         q_in;
  logic         qbar_in;

  // Requesters and the latch feedback path
  modport master (
    output req, req_set, q_in, qbar_in,
    input  grant, busy, done, err, preset_n, clear_n
  );

  // The sequencer itself
  modport slave (
    input  req, req_set, q_in, qbar_in,
    output grant, busy, done, err, preset_n, clear_n
  );
endinterface

`default_nettype wire

// File: rtl/sr_latch_sequencer.sv
// ============================================================================
//  Module      : sr_latch_sequencer
//  Description : Round-robin arbiter that shares one cross-coupled NAND latch
//                among N requesters, pulsing preset_n/clear_n, waiting for the
//                latch to settle and checking its q/qbar feedback.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_latch_sequencer #(
  parameter int N        = 2,
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 3
) (
  input  wire logic           clk,
  input  wire logic           rst,
  sr_latch_sequencer_if.slave bus
);

  localparam int CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PULSE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          op, op_nxt;
  logic [PW-1:0] winner, winner_nxt;
  logic [PW-1:0] ptr, ptr_nxt;

  logic [N-1:0]  grant, grant_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          err, err_nxt;
  logic          preset_n, preset_n_nxt;
  logic          clear_n, clear_n_nxt;

  logic          found;
  logic [PW-1:0] pick;
  logic          pass;
  int            idx;

  // Round-robin search: first asserted request at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= 1'b0;
      winner   <= '0;
      ptr      <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      preset_n <= 1'b1;
      clear_n  <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      op       <= op_nxt;
      winner   <= winner_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      preset_n <= preset_n_nxt;
      clear_n  <= clear_n_nxt;
    end
  end

  // Sequencing: IDLE -> PULSE -> SETTLE -> CHECK -> IDLE
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op;
    winner_nxt = winner;
    ptr_nxt    = ptr;
    case (state)
      IDLE: begin
        // The done cycle is skipped so the served requester can drop req
        if (!done && found) begin
          state_nxt  = PULSE;
          cnt_nxt    = CW'(PULSE_W - 1);
          op_nxt     = bus.req_set[pick];
          winner_nxt = pick;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(SETTLE_W - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = CHECK;
        else           cnt_nxt   = cnt - 1'b1;
      end
      CHECK: begin
        state_nxt = IDLE;
        ptr_nxt   = (int'(winner) == N - 1) ? '0 : winner + PW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; pulse lines decode from next state
  always_comb begin
    pass = op ? (bus.q_in && !bus.qbar_in) : (!bus.q_in && bus.qbar_in);

    grant_nxt = grant;
    if (state == IDLE) begin
      grant_nxt = '0;
      if (!done && found) grant_nxt[pick] = 1'b1;
    end

    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = (state == CHECK);
    err_nxt      = (state == CHECK) ? !pass : 1'b0;
    preset_n_nxt = !((state_nxt == PULSE) &&  op_nxt);
    clear_n_nxt  = !((state_nxt == PULSE) && !op_nxt);
  end

  assign bus.grant    = grant;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.preset_n = preset_n;
  assign bus.clear_n  = clear_n;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_sequencer.sv
// ============================================================================
//  Module      : tb_sr_latch_sequencer
//  Description : Scoreboard bench for sr_latch_sequencer with a behavioural
//                NAND latch and a transaction-level round-robin model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_sequencer;

  localparam int N        = 2;
  localparam int PULSE_W  = 2;
  localparam int SETTLE_W = 3;
  localparam int LAT      = PULSE_W + SETTLE_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sr_latch_sequencer_if #(.N(N)) bus ();

  sr_latch_sequencer #(.N(N), .PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural NAND latch: follows whichever line is low; forcing models a fault
  bit lq        = 1'b0;
  bit force_bad = 1'b0;
  bit both_low  = 1'b0;
  always @(negedge clk) begin
    if (!bus.preset_n && !bus.clear_n) both_low = 1'b1;
    else if (!bus.preset_n)            lq = 1'b1;
    else if (!bus.clear_n)             lq = 1'b0;
  end
  assign bus.q_in    = force_bad ? 1'b1 : lq;
  assign bus.qbar_in = force_bad ? 1'b1 : ~lq;

  typedef struct {
    int grant;
    int err;
    int issue;
    int q;
    bit chk_q;
  } exp_t;
  exp_t sbq[$];

  // Reference arbiter state
  int rr   = 0;
  int mask = 0;
  int ops  = 0;

  function automatic int pick_winner(input int m, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (((m >> k) & 1) == 1) return k;
    end
    return -1;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected op
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("done_grant", int'(bus.grant), e.grant);
        check("done_err", int'(bus.err), e.err);
        check("done_latency", cyc - e.issue, LAT);
        check("done_busy", int'(bus.busy), 0);
        if (e.chk_q) check("latch_q", int'(bus.q_in), e.q);
      end
    end
  end

  // One arbitration round issued at the current negedge (DUT idle, not done)
  task automatic run_op(input bit bad, input bit drop_early, input bit flip_op);
    int   w;
    int   opw;
    int   k;
    exp_t e;
    w = pick_winner(mask, rr);
    if (w < 0) begin
      bus.req = '0;
      repeat (3) @(negedge clk);
      check("idle_grant", int'(bus.grant), 0);
      check("idle_busy", int'(bus.busy), 0);
      mask = $urandom_range(1, (1 << N) - 1);
      return;
    end
    opw         = (ops >> w) & 1;
    bus.req     = N'(mask);
    bus.req_set = N'(ops);
    force_bad   = bad;
    e.grant = 1 << w;
    e.err   = bad ? 1 : 0;
    e.issue = cyc;
    e.q     = opw;
    e.chk_q = !bad;
    sbq.push_back(e);
    rr = (w + 1) % N;

    @(negedge clk);
    check("pulse_active", opw ? int'(bus.preset_n) : int'(bus.clear_n), 0);
    check("pulse_other",  opw ? int'(bus.clear_n) : int'(bus.preset_n), 1);
    if (drop_early) mask = mask & ~(1 << w);
    if (flip_op)    ops  = ops ^ (1 << w);
    bus.req     = N'(mask);
    bus.req_set = N'(ops);

    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      checks++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", LAT);
      sbq.delete();
    end
    force_bad   = 1'b0;
    mask        = (mask & ~(1 << w)) | ($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, (1 << N) - 1));
    ops         = $urandom_range(0, (1 << N) - 1);
    bus.req     = N'(mask);
    bus.req_set = N'(ops);
    @(negedge clk);
  endtask

  initial begin
    bus.req     = '0;
    bus.req_set = '0;
    repeat (3) @(negedge clk);
    check("rst_preset_n", int'(bus.preset_n), 1);
    check("rst_clear_n", int'(bus.clear_n), 1);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Set via requester 0, then clear via requester 1
    mask = 1; ops = 1;
    run_op(1'b0, 1'b0, 1'b0);
    mask = 2; ops = 0;
    run_op(1'b0, 1'b0, 1'b0);
    // Both requesting continuously
    mask = 3; ops = 2;
    run_op(1'b0, 1'b0, 1'b0);
    mask = mask | 3;
    run_op(1'b0, 1'b0, 1'b0);
    // Corrupted feedback, then early drop with op flip
    mask = 1; ops = 1;
    run_op(1'b1, 1'b0, 1'b0);
    mask = 2; ops = 0;
    run_op(1'b0, 1'b1, 1'b1);
    mask = 0;
    run_op(1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_op($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);

    // Reset in the middle of a set pulse
    bus.req     = 2'b01;
    bus.req_set = 2'b01;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_preset_n", int'(bus.preset_n), 1);
    check("midrst_clear_n", int'(bus.clear_n), 1);
    check("midrst_grant", int'(bus.grant), 0);
    check("midrst_busy", int'(bus.busy), 0);
    rst         = 1'b0;
    bus.req     = '0;
    rr          = 0;
    @(negedge clk);
    mask = 3; ops = 0;
    run_op(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("never_both_low", int'(both_low), 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
